// File: rtl/ralu_op_sequencer.sv
// Multi-cycle command sequencer driving the 4-bit register-file ALU control word.
// Optional zero flag: define RALU_SEQ_ZFLAG_EN to capture (r_i == 0) alongside the carry.
module ralu_op_sequencer #(
  parameter int ADR_W  = 3,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADR_W-1:0]  cmd_ra_i,
  input  logic [ADR_W-1:0]  cmd_rb_i,
  input  logic [ADR_W-1:0]  cmd_rd_i,
  input  logic [3:0]        cmd_s_i,
  input  logic              cmd_m_i,
  input  logic              cmd_p0_i,
  input  logic [CNT_W-1:0]  cmd_cnt_i,
  input  logic              cmd_sin_i,
  input  logic [DATA_W-1:0] r_i,
  input  logic              p4_i,
  output logic [3:0]        s_o,
  output logic              m_o,
  output logic              p0_o,
  output logic              a_o,
  output logic [2:0]        v_o,
  output logic              wr_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic              isl_o,
  output logic              isr_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  // state | meaning
  // IDLE  | waiting for a command
  // LDA   | load RgA from RON[ra] or DataIn (RI)
  // LDB   | load RgB from RON[rb]
  // SHIFT | shift RgB cnt+1 times
  // EXEC  | ALU function applied, result written to RON[rd] and captured
  // DONE  | completion pulse; may accept the next command
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LDA,
    ST_LDB,
    ST_SHIFT,
    ST_EXEC,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_RR  = 2'b00;
  localparam logic [1:0] OP_RI  = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  localparam logic [2:0] V_NONE = 3'b000;
  localparam logic [2:0] V_LDA  = 3'b001;
  localparam logic [2:0] V_SHL  = 3'b010;
  localparam logic [2:0] V_SHR  = 3'b100;
  localparam logic [2:0] V_LDB  = 3'b110;

  state_t state, state_nxt;

  logic [1:0]       op_q;
  logic [ADR_W-1:0] ra_q;
  logic [ADR_W-1:0] rb_q;
  logic [ADR_W-1:0] rd_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             p0_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sin_q;
  logic [CNT_W-1:0] shcnt_q;

  logic accept;
  logic is_shift_op;

  assign accept      = cmd_valid_i & cmd_ready_o;
  assign is_shift_op = (op_q == OP_SHL) || (op_q == OP_SHR);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      p0_q     <= 1'b0;
      cnt_q    <= '0;
      sin_q    <= 1'b0;
      shcnt_q  <= '0;
      result_o <= '0;
      carry_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= cmd_op_i;
        ra_q  <= cmd_ra_i;
        rb_q  <= cmd_rb_i;
        rd_q  <= cmd_rd_i;
        s_q   <= cmd_s_i;
        m_q   <= cmd_m_i;
        p0_q  <= cmd_p0_i;
        cnt_q <= cmd_cnt_i;
        sin_q <= cmd_sin_i;
      end
      // Shift counter is armed in LDB and counts down to zero inside SHIFT.
      if (state == ST_LDB) begin
        shcnt_q <= cnt_q;
      end else if ((state == ST_SHIFT) && (shcnt_q != '0)) begin
        shcnt_q <= shcnt_q - CNT_W'(1);
      end
      if (state == ST_EXEC) begin
        result_o <= r_i;
        carry_o  <= p4_i;
      end
    end
  end

`ifdef RALU_SEQ_ZFLAG_EN
  logic zero_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      zero_q <= 1'b0;
    end else if (state == ST_EXEC) begin
      zero_q <= (r_i == '0);
    end
  end

  assign zero_o = zero_q;
`else
  assign zero_o = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    done_o      = 1'b0;
    s_o         = '0;
    m_o         = 1'b0;
    p0_o        = 1'b0;
    a_o         = 1'b0;
    v_o         = V_NONE;
    wr_o        = 1'b0;
    adr_o       = '0;
    isl_o       = 1'b0;
    isr_o       = 1'b0;

    case (state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nxt = ST_LDA;
      end
      ST_LDA: begin
        v_o       = V_LDA;
        adr_o     = ra_q;
        a_o       = (op_q == OP_RI);
        state_nxt = ST_LDB;
      end
      ST_LDB: begin
        // RgB takes its own cycle: the RALU has a single RON address port.
        v_o       = V_LDB;
        adr_o     = rb_q;
        state_nxt = is_shift_op ? ST_SHIFT : ST_EXEC;
      end
      ST_SHIFT: begin
        if (op_q == OP_SHL) begin
          v_o   = V_SHL;
          isl_o = sin_q;
        end else begin
          v_o   = V_SHR;
          isr_o = sin_q;
        end
        if (shcnt_q == '0) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        s_o       = s_q;
        m_o       = m_q;
        p0_o      = p0_q;
        wr_o      = 1'b1;
        adr_o     = rd_q;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_o      = 1'b1;
        cmd_ready_o = 1'b1;
        state_nxt   = cmd_valid_i ? ST_LDA : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ralu_op_sequencer.md
Name: ralu_op_sequencer

Overview:
- Multi-cycle control sequencer for the 4-bit register-file ALU (8-entry RON, operand regs RgA/RgB, shiftable RgB).
- Accepts one register-level command at a time over a valid/ready handshake.
- Emits the per-cycle RALU control word: operand loads, RgB shifts, function select, RON write-back.
- Captures the result and carry into status registers and pulses done_o.

Parameters:
- ADR_W, 3, RON address width (8 registers).
- DATA_W, 4, datapath width.
- CNT_W, 2, shift-count field width; shifts performed = cnt+1.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  sequencer can accept a command.
- cmd_op_i  in  2  00 RR, 01 RI, 10 SHL, 11 SHR.
- cmd_ra_i  in  ADR_W  source register for RgA.
- cmd_rb_i  in  ADR_W  source register for RgB.
- cmd_rd_i  in  ADR_W  destination register.
- cmd_s_i  in  4  ALU function select.
- cmd_m_i  in  1  ALU mode.
- cmd_p0_i  in  1  ALU carry-in.
- cmd_cnt_i  in  CNT_W  shift count minus one.
- cmd_sin_i  in  1  serial bit shifted into RgB.
- r_i  in  DATA_W  RALU result (R_o).
- p4_i  in  1  RALU carry-out (P4_o).
- s_o  out  4  to RALU S_i.
- m_o  out  1  to RALU M_i.
- p0_o  out  1  to RALU P0_i.
- a_o  out  1  to RALU A_i; 1 selects DataIn.
- v_o  out  3  to RALU v_i.
- wr_o  out  1  to RALU wr_i.
- adr_o  out  ADR_W  to RALU adr_i.
- isl_o  out  1  to RALU ISL_i.
- isr_o  out  1  to RALU ISR_i.
- done_o  out  1  one-cycle completion pulse.
- result_o  out  DATA_W  captured result.
- carry_o  out  1  captured carry.
- zero_o  out  1  captured zero flag (see Optional Feature).

Behaviour:
- FSM states: IDLE, LDA, LDB, SHIFT, EXEC, DONE.
- Moore outputs: control outputs are decoded combinationally from state plus latched command fields.
- IDLE/DONE: v_o=000, wr_o=0, a_o=0, adr_o=0, isl_o=isr_o=0, s_o/m_o/p0_o=0.
- Reset (rst_n_i low at a clock edge, any state, including mid-SHIFT/EXEC):
  - state<=IDLE; shift counter, latched command, result_o, carry_o, zero_o <=0.
  - No wr_o is asserted in the cycle following reset.
- cmd_ready_o=1 in IDLE and DONE, else 0.
- Accept on cmd_valid_i & cmd_ready_o:
  - Latch all cmd_* fields.
  - Go to LDA.
  - cmd_valid_i while busy is ignored; no buffering.
- LDA: v_o=001, adr_o=ra.
  - a_o=1 for RI (RgA<=DataIn, driven externally); a_o=0 otherwise (RgA<=RON[ra]).
  - Next state: LDB.
- LDB: v_o=110, adr_o=rb (RgB<=RON[rb]).
  - Next: EXEC for RR/RI; SHIFT for SHL/SHR, with counter<=cnt.
  - RgA and RgB are loaded in separate cycles because the RALU shares one adr port.
- SHIFT:
  - SHL: v_o=010, isl_o=sin.
  - SHR: v_o=100, isr_o=sin.
  - Stays cnt+1 cycles; counter decrements each cycle; exits to EXEC when counter==0 in that cycle.
- EXEC: s_o/m_o/p0_o from the latched command, v_o=000, wr_o=1, adr_o=rd.
  - Same edge: result_o<=r_i, carry_o<=p4_i.
  - Next state: DONE.
- DONE: done_o=1 for exactly this cycle.
  - New command accepted here goes directly to LDA (back-to-back, no IDLE bubble); otherwise goes to IDLE.
- Latency, accept edge to done_o high:
  - RR/RI: 4 cycles.
  - SHL/SHR: 4+cnt+1 cycles.
  - Issue rate: one command per 4 (+shifts) cycles.
- rd equal to ra or rb is legal. Operands are already in RgA/RgB before the write, so the old values are used.
- s_o/m_o/p0_o are valid only in EXEC; elsewhere 0.
- result_o, carry_o, zero_o hold their values until the next EXEC or reset.

Optional Feature:
- Macro RALU_SEQ_ZFLAG_EN.
- Defined: zero_o<=(r_i==0) at the EXEC edge, held like carry_o.
- Undefined: zero_o is constant 0, and the flag register and comparator are absent.
- Port list is identical in both builds.

Test Plan:
- Reset check: hold rst_n_i low 2 cycles mid-operation, release.
  - Required: state IDLE, cmd_ready_o=1, v_o=000, wr_o=0, done_o=0, result_o=0, carry_o=0.
- RR: op=00, ra=2, rb=5, rd=7, s=1001, m=0, p0=1; bench drives r_i=4'hA, p4_i=1 in EXEC.
  - Required cycle trace after accept: (v_o=001, adr_o=2, a_o=0) → (v_o=110, adr_o=5) → (wr_o=1, adr_o=7, s_o=1001, p0_o=1).
  - Then done_o=1, result_o=A, carry_o=1.
- RI: op=01, rb=3, rd=3.
  - Required: a_o=1 in LDA; LDB adr_o=3; EXEC adr_o=3, wr_o=1.
- Shift: op=10, cnt=2, sin=1.
  - Required: exactly 3 cycles of v_o=010 with isl_o=1 between LDB and EXEC; done_o 7 cycles after accept.
  - Repeat with op=11: 3 cycles of v_o=100 with isr_o=1.
- Handshake: cmd_valid_i held high continuously with two RR commands.
  - Required: second command accepted in the DONE cycle of the first; its LDA follows immediately; cmd_valid_i during LDA..EXEC is not accepted.
- Zero flag: EXEC with r_i=0.
  - With RALU_SEQ_ZFLAG_EN: zero_o=1, then 0 after a next command with r_i=5.
  - Without the macro: zero_o stays 0.
